// File: rtl/sim_mem_bridge.sv
// sim_mem_bridge: simulation-only bridge from NUM_CH cache command/response channels to a single
// RAMHelper-style word port. It round-robin arbitrates the channels, extracts size-aligned read
// data, and returns responses through a fixed LATENCY-deep pipeline with per-channel flush.
//
// Ports:
//   clock, reset_n          clock; asynchronous active-low reset
//   cmd_valid/cmd_ready     per-channel request handshake (ready is one-hot or zero)
//   cmd_addr/wen/wdata/     per-channel request fields, channel i at [W*i +: W]
//   cmd_wstrb/cmd_size
//   flush                   per-channel drop of all in-flight responses
//   rsp_valid/rsp_data      per-channel one-cycle response pulse and data
//   ram_*                   combinational word port driven from the granted channel
//   busy                    any response stage holds a valid entry
module sim_mem_bridge #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned LATENCY   = 1,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned IDX_W     = 28,
    parameter bit          WRITE_ACK = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_CH-1:0]    cmd_valid,
    output logic [NUM_CH-1:0]    cmd_ready,
    input  logic [NUM_CH*64-1:0] cmd_addr,
    input  logic [NUM_CH-1:0]    cmd_wen,
    input  logic [NUM_CH*64-1:0] cmd_wdata,
    input  logic [NUM_CH*8-1:0]  cmd_wstrb,
    input  logic [NUM_CH*3-1:0]  cmd_size,
    input  logic [NUM_CH-1:0]    flush,
    output logic [NUM_CH-1:0]    rsp_valid,
    output logic [NUM_CH*64-1:0] rsp_data,
    output logic                 ram_en,
    output logic [IDX_W-1:0]     ram_rIdx,
    output logic [IDX_W-1:0]     ram_wIdx,
    input  logic [63:0]          ram_rdata,
    output logic [63:0]          ram_wdata,
    output logic [63:0]          ram_wmask,
    output logic                 ram_wen,
    output logic                 busy
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned LAST = LATENCY - 1;

    typedef logic [CH_W-1:0] ch_t;

    ch_t         ptr_q, ptr_d;
    logic        grant;
    ch_t         grant_ch;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic        sel_wen;
    logic [7:0]  sel_wstrb;
    logic [2:0]  sel_size;
    logic [63:0] offset;
    logic [63:0] shifted;
    logic [63:0] aligned;

    logic        stg_valid_q [LATENCY];
    logic        stg_valid_d [LATENCY];
    ch_t         stg_ch_q    [LATENCY];
    ch_t         stg_ch_d    [LATENCY];
    logic [63:0] stg_data_q  [LATENCY];
    logic [63:0] stg_data_d  [LATENCY];

    // Round-robin scan starting at ptr_q; requests are ignored while reset is asserted.
    always_comb begin : p_arb
        ch_t idx;
        idx      = '0;
        grant    = 1'b0;
        grant_ch = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = ch_t'((32'(ptr_q) + k) % NUM_CH);
            if (!grant && cmd_valid[idx] && reset_n) begin
                grant    = 1'b1;
                grant_ch = idx;
            end
        end
    end

    always_comb begin : p_sel
        cmd_ready = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wen   = 1'b0;
        sel_wstrb = '0;
        sel_size  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (grant && (grant_ch == ch_t'(k))) begin
                cmd_ready[k] = 1'b1;
                sel_addr     = cmd_addr[64*k +: 64];
                sel_wdata    = cmd_wdata[64*k +: 64];
                sel_wen      = cmd_wen[k];
                sel_wstrb    = cmd_wstrb[8*k +: 8];
                sel_size     = cmd_size[3*k +: 3];
            end
        end
    end

    always_comb begin : p_ptr
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = ch_t'((32'(grant_ch) + 1) % NUM_CH);
        end
    end

    // RAM port; every field is zero without a grant because the sel_* defaults are zero.
    assign offset = sel_addr - BASE_ADDR;

    always_comb begin : p_ram
        ram_en    = grant;
        ram_wen   = grant & sel_wen;
        ram_rIdx  = grant ? offset[IDX_W+2:3] : '0;
        ram_wIdx  = grant ? offset[IDX_W+2:3] : '0;
        ram_wdata = sel_wdata;
        ram_wmask = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            ram_wmask[8*b +: 8] = {8{sel_wstrb[b]}};
        end
    end

    logic unused_offset;
    assign unused_offset = ^{offset[63:IDX_W+3], offset[2:0]};

    // Misaligned accesses simply return whatever the shift produces.
    assign shifted = ram_rdata >> {sel_addr[2:0], 3'b000};

    always_comb begin : p_align
        case (sel_size)
            3'd0:    aligned = {56'd0, shifted[7:0]};
            3'd1:    aligned = {48'd0, shifted[15:0]};
            3'd2:    aligned = {32'd0, shifted[31:0]};
            default: aligned = shifted;
        endcase
    end

    // A flush kills matching entries as they move, including a same-cycle capture.
    always_comb begin : p_pipe
        stg_valid_d[0] = grant && (!sel_wen || WRITE_ACK) && !flush[grant_ch];
        stg_ch_d[0]    = grant_ch;
        stg_data_d[0]  = sel_wen ? 64'd0 : aligned;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            stg_valid_d[i] = stg_valid_q[i-1] && !flush[stg_ch_q[i-1]];
            stg_ch_d[i]    = stg_ch_q[i-1];
            stg_data_d[i]  = stg_data_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stg_valid_q[i] <= 1'b0;
                stg_ch_q[i]    <= '0;
                stg_data_q[i]  <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stg_valid_q[i] <= stg_valid_d[i];
                stg_ch_q[i]    <= stg_ch_d[i];
                stg_data_q[i]  <= stg_data_d[i];
            end
        end
    end

    // A flush arriving with the final-stage entry of its channel suppresses the response.
    always_comb begin : p_rsp
        rsp_valid = '0;
        rsp_data  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (stg_valid_q[LAST] && (stg_ch_q[LAST] == ch_t'(k)) && !flush[k]) begin
                rsp_valid[k]        = 1'b1;
                rsp_data[64*k +: 64] = stg_data_q[LAST];
            end
        end
    end

    always_comb begin : p_busy
        busy = 1'b0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            busy = busy | stg_valid_q[i];
        end
    end

endmodule

// File: tb/tb_sim_mem_bridge.sv
// Directed bench for sim_mem_bridge. Three instances share one stimulus stream:
//   d=0: LATENCY=1, WRITE_ACK=0    d=1: LATENCY=4, WRITE_ACK=0    d=2: LATENCY=2, WRITE_ACK=1
// Each instance has its own 16-word RAM model. Inputs change on the falling edge and outputs
// are checked 1 ns later.
module tb_sim_mem_bridge;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset_n;
    logic [1:0]   cmd_valid;
    logic [127:0] cmd_addr;
    logic [1:0]   cmd_wen;
    logic [127:0] cmd_wdata;
    logic [15:0]  cmd_wstrb;
    logic [5:0]   cmd_size;
    logic [1:0]   flush;

    logic [1:0]   ready [3];
    logic [1:0]   rv    [3];
    logic [127:0] rd    [3];
    logic         en    [3];
    logic [27:0]  ridx  [3];
    logic [27:0]  widx  [3];
    logic [63:0]  rdata [3];
    logic [63:0]  wdata [3];
    logic [63:0]  wmask [3];
    logic         wen   [3];
    logic         busy  [3];

    int checks   = 0;
    int failures = 0;

    function automatic logic [63:0] init_word(input int k);
        case (k)
            0:       return 64'h1122_3344_5566_7788;
            1:       return 64'h0102_0304_0506_0708;
            2:       return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {32'hC0DE_0000 + 32'(k), 32'(k)};
        endcase
    endfunction

    for (genvar d = 0; d < 3; d++) begin : g_dut
        logic [63:0] mem [16];

        initial begin
            for (int k = 0; k < 16; k++) mem[k] <= init_word(k);
        end

        assign rdata[d] = (ridx[d] < 28'd16) ? mem[ridx[d][3:0]] : 64'd0;

        always @(posedge clock) begin
            if (wen[d] && (widx[d] < 28'd16)) begin
                mem[widx[d][3:0]] <= (mem[widx[d][3:0]] & ~wmask[d]) | (wdata[d] & wmask[d]);
            end
        end

        sim_mem_bridge #(
            .NUM_CH   (2),
            .LATENCY  ((d == 0) ? 1 : ((d == 1) ? 4 : 2)),
            .BASE_ADDR(64'h8000_0000),
            .IDX_W    (28),
            .WRITE_ACK(d == 2)
        ) u_dut (
            .clock    (clock),
            .reset_n  (reset_n),
            .cmd_valid(cmd_valid),
            .cmd_ready(ready[d]),
            .cmd_addr (cmd_addr),
            .cmd_wen  (cmd_wen),
            .cmd_wdata(cmd_wdata),
            .cmd_wstrb(cmd_wstrb),
            .cmd_size (cmd_size),
            .flush    (flush),
            .rsp_valid(rv[d]),
            .rsp_data (rd[d]),
            .ram_en   (en[d]),
            .ram_rIdx (ridx[d]),
            .ram_wIdx (widx[d]),
            .ram_rdata(rdata[d]),
            .ram_wdata(wdata[d]),
            .ram_wmask(wmask[d]),
            .ram_wen  (wen[d]),
            .busy     (busy[d])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        cmd_valid = '0;
        cmd_wen   = '0;
        flush     = '0;
    endtask

    task automatic next();
        @(negedge clock);
        idle();
    endtask

    task automatic set_rd(input int ch, input logic [63:0] a, input logic [2:0] sz);
        cmd_valid[ch]          = 1'b1;
        cmd_wen[ch]            = 1'b0;
        cmd_addr[64*ch +: 64]  = a;
        cmd_size[3*ch +: 3]    = sz;
    endtask

    task automatic set_wr(input int ch, input logic [63:0] a, input logic [63:0] wd,
                          input logic [7:0] ws);
        cmd_valid[ch]          = 1'b1;
        cmd_wen[ch]            = 1'b1;
        cmd_addr[64*ch +: 64]  = a;
        cmd_wdata[64*ch +: 64] = wd;
        cmd_wstrb[8*ch +: 8]   = ws;
        cmd_size[3*ch +: 3]    = 3'd3;
    endtask

    logic [63:0] rr_exp [4];

    initial begin
        rr_exp = '{64'h1122_3344_5566_7788, 64'hC0DE_0005_0000_0005,
                   64'hFFFF_FFFF_FFFF_FFFF, 64'hC0DE_0007_0000_0007};
        reset_n   = 1'b0;
        cmd_valid = 2'b11;
        cmd_wen   = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        cmd_size  = '0;
        flush     = '0;

        // Reset state, with requests present that must be ignored.
        #1;
        chk("rst_ready", 64'(ready[0]), 64'd0);
        chk("rst_ram_en", 64'(en[0]), 64'd0);
        chk("rst_ram_wen", 64'(wen[1]), 64'd0);
        chk("rst_busy", 64'(busy[1]), 64'd0);
        chk("rst_rsp_valid", 64'(rv[2]), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        idle();

        // Round-robin contention: grants 0,1,0,1; responses one cycle later on LATENCY=1.
        for (int c = 0; c < 5; c++) begin
            next();
            if (c < 4) begin
                set_rd(0, 64'h8000_0000 + 64'(8 * c), 3'd3);
                set_rd(1, 64'h8000_0020 + 64'(8 * c), 3'd3);
            end
            #1;
            if (c < 4) chk("rr_grant", 64'(ready[0]), (c % 2 == 0) ? 64'd1 : 64'd2);
            if (c >= 1) begin
                chk("rr_rsp_valid", 64'(rv[0]), ((c - 1) % 2 == 0) ? 64'd1 : 64'd2);
                chk("rr_rsp_data", rd[0][64*((c-1)%2) +: 64], rr_exp[c-1]);
            end
        end
        repeat (4) next();
        #1;
        chk("rr_drain_busy", 64'(busy[1]), 64'd0);

        // Single size-2 read at byte offset 4.
        next();
        set_rd(0, 64'h8000_0004, 3'd2);
        #1;
        chk("rd_ready", 64'(ready[0]), 64'd1);
        chk("rd_ram_en", 64'(en[0]), 64'd1);
        chk("rd_ridx", 64'(ridx[0]), 64'd0);
        chk("rd_widx", 64'(widx[0]), 64'd0);
        chk("rd_ram_wen", 64'(wen[0]), 64'd0);
        next();
        #1;
        chk("rd_rsp_l1", 64'(rv[0]), 64'd1);
        chk("rd_data_l1", rd[0][63:0], 64'h0000_0000_1122_3344);
        chk("rd_no_rsp_l2_early", 64'(rv[2]), 64'd0);
        chk("rd_busy_l4", 64'(busy[1]), 64'd1);
        next();
        #1;
        chk("rd_pulse_end_l1", 64'(rv[0]), 64'd0);
        chk("rd_rsp_l2", 64'(rv[2]), 64'd1);
        chk("rd_data_l2", rd[2][63:0], 64'h0000_0000_1122_3344);
        next();
        next();
        #1;
        chk("rd_rsp_l4", 64'(rv[1]), 64'd1);
        chk("rd_data_l4", rd[1][63:0], 64'h0000_0000_1122_3344);

        // Partial write on ch1 then read-back.
        next();
        set_wr(1, 64'h8000_0010, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F);
        #1;
        chk("wr_ready", 64'(ready[0]), 64'd2);
        chk("wr_ram_wen", 64'(wen[0]), 64'd1);
        chk("wr_wmask", wmask[0], 64'h0000_0000_FFFF_FFFF);
        chk("wr_widx", 64'(widx[0]), 64'd2);
        chk("wr_wdata", wdata[0], 64'hAAAA_BBBB_CCCC_DDDD);
        next();
        set_rd(1, 64'h8000_0010, 3'd3);
        #1;
        chk("wr_no_ack_l1", 64'(rv[0]), 64'd0);
        chk("wr_no_ack_l2_early", 64'(rv[2]), 64'd0);
        next();
        #1;
        chk("wr_rd_rsp_l1", 64'(rv[0]), 64'd2);
        chk("wr_rd_data_l1", rd[0][127:64], 64'hFFFF_FFFF_CCCC_DDDD);
        chk("wr_ack_l2", 64'(rv[2]), 64'd2);
        chk("wr_ack_data_l2", rd[2][127:64], 64'd0);
        next();
        #1;
        chk("wr_rd_rsp_l2", 64'(rv[2]), 64'd2);
        chk("wr_rd_data_l2", rd[2][127:64], 64'hFFFF_FFFF_CCCC_DDDD);
        next();
        #1;
        chk("wr_silent_l4", 64'(rv[1]), 64'd0);
        next();
        #1;
        chk("wr_rd_rsp_l4", 64'(rv[1]), 64'd2);
        chk("wr_rd_data_l4", rd[1][127:64], 64'hFFFF_FFFF_CCCC_DDDD);
        next();
        next();

        // Three ch0 reads, then flush[0] on the following cycle.
        for (int c = 0; c < 3; c++) begin
            next();
            set_rd(0, 64'h8000_0000, 3'd3);
            #1;
        end
        next();
        flush = 2'b01;
        #1;
        chk("flush_same_cycle_l1", 64'(rv[0]), 64'd0);
        chk("flush_same_cycle_l2", 64'(rv[2]), 64'd0);
        chk("flush_busy_before", 64'(busy[1]), 64'd1);
        next();
        #1;
        chk("flush_busy_l4", 64'(busy[1]), 64'd0);
        chk("flush_busy_l2", 64'(busy[2]), 64'd0);
        chk("flush_no_rsp_l4", 64'(rv[1]), 64'd0);
        for (int c = 0; c < 2; c++) begin
            next();
            #1;
            chk("flush_no_rsp_l4", 64'(rv[1]), 64'd0);
        end

        // Flush at capture: read and write on ch0 are dropped, the write still lands.
        next();
        set_rd(0, 64'h8000_0000, 3'd3);
        flush = 2'b01;
        #1;
        next();
        set_wr(0, 64'h8000_0020, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        flush = 2'b01;
        #1;
        chk("flush_cap_rd_l1", 64'(rv[0]), 64'd0);
        chk("flush_cap_wr_en", 64'(wen[0]), 64'd1);
        next();
        set_rd(1, 64'h8000_0020, 3'd3);
        #1;
        chk("flush_cap_rd_l2", 64'(rv[2]), 64'd0);
        next();
        flush = 2'b01;
        #1;
        chk("flush_other_ch_l1", 64'(rv[0]), 64'd2);
        chk("flush_wr_landed", rd[0][127:64], 64'h1234_5678_9ABC_DEF0);
        chk("flush_cap_wr_ack_l2", 64'(rv[2]), 64'd0);
        next();
        #1;
        chk("flush_other_ch_l2", 64'(rv[2]), 64'd2);
        chk("flush_other_data_l2", rd[2][127:64], 64'h1234_5678_9ABC_DEF0);
        chk("flush_cap_rd_l4", 64'(rv[1]), 64'd0);
        next();
        next();
        #1;
        chk("flush_other_ch_l4", 64'(rv[1]), 64'd2);
        chk("flush_other_data_l4", rd[1][127:64], 64'h1234_5678_9ABC_DEF0);

        // Asynchronous reset with reads in flight.
        next();
        set_rd(0, 64'h8000_0000, 3'd3);
        #1;
        next();
        set_rd(1, 64'h8000_0008, 3'd3);
        #1;
        next();
        set_rd(0, 64'h8000_0000, 3'd3);
        #1;
        next();
        #1;
        chk("pre_rst_busy", 64'(busy[1]), 64'd1);
        chk("pre_rst_rsp_l1", 64'(rv[0]), 64'd1);
        chk("pre_rst_rsp_l2", 64'(rv[2]), 64'd2);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_busy", 64'(busy[1]), 64'd0);
        chk("async_rsp_l1", 64'(rv[0]), 64'd0);
        chk("async_rsp_l2", 64'(rv[2]), 64'd0);
        chk("async_data_l1", rd[0][63:0], 64'd0);
        chk("async_data_l2", rd[2][127:64], 64'd0);
        next();
        reset_n = 1'b1;
        set_rd(0, 64'h8000_000A, 3'd1);
        set_rd(1, 64'h8000_0000, 3'd3);
        #1;
        chk("ptr_restart", 64'(ready[0]), 64'd1);
        next();
        #1;
        chk("post_rst_rsp_l1", 64'(rv[0]), 64'd1);
        chk("post_rst_data_l1", rd[0][63:0], 64'h0000_0000_0000_0506);
        chk("post_rst_stale_l4", 64'(rv[1]), 64'd0);
        for (int c = 0; c < 2; c++) begin
            next();
            #1;
            chk("post_rst_stale_l4", 64'(rv[1]), 64'd0);
        end
        next();
        #1;
        chk("post_rst_rsp_l4", 64'(rv[1]), 64'd1);
        chk("post_rst_data_l4", rd[1][63:0], 64'h0000_0000_0000_0506);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
